// File: rtl/subband_sample_scheduler_if.sv
// Scheduler bus: IMDCT sample input, granule BRAM port, filterbank vector output.
// The scheduler takes the slave side; the BRAM and its neighbours take the master side.
interface subband_sample_scheduler_if #(
    parameter int DATA_W = 32,
    parameter int NUM_SB = 32
);
    logic [DATA_W-1:0]        in_data;
    logic                     in_valid;
    logic                     in_ready;
    logic [10:0]              ram_addr;
    logic                     ram_we;
    logic [DATA_W-1:0]        ram_din;
    logic [DATA_W-1:0]        ram_dout;
    logic [NUM_SB*DATA_W-1:0] out_data;
    logic [4:0]               out_ss;
    logic                     out_last;
    logic                     out_valid;
    logic                     out_ready;

    modport slave (
        input  in_data, in_valid, ram_dout, out_ready,
        output in_ready, ram_addr, ram_we, ram_din,
        output out_data, out_ss, out_last, out_valid
    );

    modport master (
        output in_data, in_valid, ram_dout, out_ready,
        input  in_ready, ram_addr, ram_we, ram_din,
        input  out_data, out_ss, out_last, out_valid
    );
endinterface

// File: rtl/subband_sample_scheduler.sv
// Ping-pong granule BRAM scheduler between the IMDCT writer and the synthesis filterbank.
// Optional: define SUBBAND_SCHED_FREQ_INV_EN to negate odd-sb lanes of odd-ss vectors.
module subband_sample_scheduler #(
    parameter int DATA_W  = 32,
    parameter int NUM_SB  = 32,
    parameter int NUM_SS  = 18,
    parameter int RAM_LAT = 2
) (
    input logic                       clk,
    input logic                       rst_n,
    subband_sample_scheduler_if.slave bus
);
    localparam int BANK_SZ = NUM_SB * NUM_SS;
    localparam int SB_W    = $clog2(NUM_SB);
    localparam int CNT_W   = $clog2(BANK_SZ);

    localparam logic [1:0] B_EMPTY = 2'd0;
    localparam logic [1:0] B_FILL  = 2'd1;
    localparam logic [1:0] B_FULL  = 2'd2;
    localparam logic [1:0] B_DRAIN = 2'd3;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_GATHER  = 2'd1;
    localparam logic [1:0] S_FLUSH   = 2'd2;
    localparam logic [1:0] S_PRESENT = 2'd3;

    localparam logic [RAM_LAT-1:0] LAST_MSK = RAM_LAT'(1) << (RAM_LAT - 1);

    logic [1:0]               r_bank_st [2];
    logic                     r_wr_bank;
    logic                     r_rd_bank;
    logic [CNT_W-1:0]         r_wr_cnt;
    logic [1:0]               r_state;
    logic [SB_W-1:0]          r_sb;
    logic [4:0]               r_ss;
    logic [RAM_LAT-1:0]       r_tag_v;
    logic [SB_W-1:0]          r_tag_sb [RAM_LAT];
    logic [NUM_SB*DATA_W-1:0] r_out_data;
    logic                     r_out_valid;

    logic [1:0]        w_bank_nx [2];
    logic              w_in_ready;
    logic              w_wr;
    logic              w_wr_done;
    logic              w_rd;
    logic              w_rd_take;
    logic              w_rd_free;
    logic              w_ss_last;
    logic              w_pipe_busy;
    logic [10:0]       w_wr_addr;
    logic [10:0]       w_rd_addr;
    logic [DATA_W-1:0] w_lane;

    assign w_in_ready = (r_bank_st[r_wr_bank] == B_EMPTY) ||
                        (r_bank_st[r_wr_bank] == B_FILL);
    assign w_wr       = bus.in_valid & w_in_ready & rst_n;
    assign w_wr_done  = w_wr && (r_wr_cnt == CNT_W'(BANK_SZ - 1));
    assign w_ss_last  = (r_ss == 5'(NUM_SS - 1));
    // Writer owns the port whenever it has data; reads fill the gaps.
    assign w_rd       = (r_state == S_GATHER) && !w_wr;
    assign w_rd_take  = (r_state == S_IDLE) && (r_bank_st[r_rd_bank] == B_FULL);
    assign w_rd_free  = (r_state == S_PRESENT) && bus.out_ready && w_ss_last;
    assign w_pipe_busy = |(r_tag_v & ~LAST_MSK);

    assign w_wr_addr = (r_wr_bank ? 11'(BANK_SZ) : 11'd0) + 11'(r_wr_cnt);
    assign w_rd_addr = (r_rd_bank ? 11'(BANK_SZ) : 11'd0) +
                       11'(r_sb) * 11'(NUM_SS) + 11'(r_ss);

`ifdef SUBBAND_SCHED_FREQ_INV_EN
    assign w_lane = (r_tag_sb[RAM_LAT-1][0] & r_ss[0]) ?
                    (DATA_W'(0) - bus.ram_dout) : bus.ram_dout;
`else
    assign w_lane = bus.ram_dout;
`endif

    assign bus.in_ready  = w_in_ready;
    assign bus.ram_we    = w_wr;
    assign bus.ram_din   = w_wr ? bus.in_data : '0;
    assign bus.ram_addr  = w_wr ? w_wr_addr : (w_rd ? w_rd_addr : 11'd0);
    assign bus.out_data  = r_out_data;
    assign bus.out_ss    = r_ss;
    assign bus.out_last  = r_out_valid & w_ss_last;
    assign bus.out_valid = r_out_valid;

    // Writer and reader only ever touch different banks, so both updates may land together.
    always_comb begin
        w_bank_nx[0] = r_bank_st[0];
        w_bank_nx[1] = r_bank_st[1];
        if (w_rd_take) w_bank_nx[r_rd_bank] = B_DRAIN;
        if (w_rd_free) w_bank_nx[r_rd_bank] = B_EMPTY;
        if (w_wr)      w_bank_nx[r_wr_bank] = w_wr_done ? B_FULL : B_FILL;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bank_st[0] <= B_EMPTY;
            r_bank_st[1] <= B_EMPTY;
            r_wr_bank    <= 1'b0;
            r_wr_cnt     <= '0;
        end else begin
            r_bank_st[0] <= w_bank_nx[0];
            r_bank_st[1] <= w_bank_nx[1];
            if (w_wr_done) begin
                r_wr_cnt  <= '0;
                r_wr_bank <= ~r_wr_bank;
            end else if (w_wr) begin
                r_wr_cnt <= r_wr_cnt + 1'b1;
            end
        end
    end

    // Tag pipe tracks which lane each in-flight read belongs to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag_v    <= '0;
            r_out_data <= '0;
            for (int k = 0; k < RAM_LAT; k++) r_tag_sb[k] <= '0;
        end else begin
            r_tag_v[0]  <= w_rd;
            r_tag_sb[0] <= r_sb;
            for (int k = RAM_LAT - 1; k > 0; k--) begin
                r_tag_v[k]  <= r_tag_v[k-1];
                r_tag_sb[k] <= r_tag_sb[k-1];
            end
            if (r_tag_v[RAM_LAT-1])
                r_out_data[r_tag_sb[RAM_LAT-1]*DATA_W +: DATA_W] <= w_lane;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_rd_bank   <= 1'b0;
            r_sb        <= '0;
            r_ss        <= '0;
            r_out_valid <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: if (w_rd_take) begin
                    r_ss    <= '0;
                    r_sb    <= '0;
                    r_state <= S_GATHER;
                end
                S_GATHER: if (w_rd) begin
                    if (r_sb == SB_W'(NUM_SB - 1)) begin
                        r_sb    <= '0;
                        r_state <= S_FLUSH;
                    end else begin
                        r_sb <= r_sb + 1'b1;
                    end
                end
                // Raise valid on the edge that captures the final lane.
                S_FLUSH: if (!w_pipe_busy) begin
                    r_out_valid <= 1'b1;
                    r_state     <= S_PRESENT;
                end
                S_PRESENT: if (bus.out_ready) begin
                    r_out_valid <= 1'b0;
                    if (w_ss_last) begin
                        r_rd_bank <= ~r_rd_bank;
                        r_state   <= S_IDLE;
                    end else begin
                        r_ss    <= r_ss + 1'b1;
                        r_state <= S_GATHER;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_subband_sample_scheduler.sv
// Scoreboard bench for subband_sample_scheduler with a behavioural RAM_LAT-cycle BRAM.
// Expected vectors and writes are queued at stimulus time and popped by monitors.
module tb_subband_sample_scheduler;
    localparam int DW  = 32;
    localparam int NSB = 32;
    localparam int NSS = 18;
    localparam int LAT = 2;
    localparam int BSZ = NSB * NSS;

    typedef struct {
        logic [NSB*DW-1:0] d;
        logic [4:0]        ss;
        logic              last;
    } vec_t;

    typedef struct {
        logic [10:0]   a;
        logic [DW-1:0] d;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    subband_sample_scheduler_if #(.DATA_W(DW), .NUM_SB(NSB)) bus();

    subband_sample_scheduler #(
        .DATA_W(DW), .NUM_SB(NSB), .NUM_SS(NSS), .RAM_LAT(LAT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    logic [DW-1:0] mem [2048];
    logic [DW-1:0] rp [LAT];

    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
        rp[0] <= mem[bus.ram_addr];
        for (int k = 1; k < LAT; k++) rp[k] <= rp[k-1];
    end
    assign bus.ram_dout = rp[LAT-1];

    vec_t exp_q[$];
    wr_t  wq[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_rx = 0;
    int   stalls = 0;
    int   wbank = 0;

    logic              hold = 1'b0;
    logic [NSB*DW-1:0] h_d;
    logic [4:0]        h_ss;
    logic              h_last;

    function automatic logic [DW-1:0] sval(input int g, input int sb, input int ss);
        if (g == 6) return 32'd5;
        return 32'((g << 16) | (sb * NSS + ss));
    endfunction

    function automatic logic [DW-1:0] lane(input logic [DW-1:0] x, input int sb, input int ss);
`ifdef SUBBAND_SCHED_FREQ_INV_EN
        if ((sb % 2 == 1) && (ss % 2 == 1)) return 32'd0 - x;
`endif
        return x;
    endfunction

    task automatic summary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL timeout %s: got no event want event within bound", nm);
        summary();
        $finish;
    endtask

    task automatic check_vec(input vec_t v);
        int first;
        first = -1;
        n_cmp++;
        if (bus.out_data !== v.d) begin
            n_bad++;
            for (int k = NSB - 1; k >= 0; k--)
                if (bus.out_data[k*DW +: DW] !== v.d[k*DW +: DW]) first = k;
            $display("FAIL vec_data ss=%0d lane %0d: got 0x%0h want 0x%0h", v.ss, first,
                     bus.out_data[first*DW +: DW], v.d[first*DW +: DW]);
        end
        chk("vec_ss", 64'(bus.out_ss), 64'(v.ss));
        chk("vec_last", 64'(bus.out_last), 64'(v.last));
    endtask

    always @(negedge clk) begin
        wr_t w;
        vec_t v;
        if (rst_n && bus.ram_we) begin
            if (wq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL wr_unexpected: got addr %0d want no write", bus.ram_addr);
            end else begin
                w = wq.pop_front();
                chk("wr_addr", 64'(bus.ram_addr), 64'(w.a));
                chk("wr_din", 64'(bus.ram_din), 64'(w.d));
            end
        end
        if (rst_n && hold) begin
            n_cmp++;
            if (!bus.out_valid || bus.out_data !== h_d ||
                bus.out_ss !== h_ss || bus.out_last !== h_last) begin
                n_bad++;
                $display("FAIL stable: got v=%b ss=%0d last=%b want v=1 ss=%0d last=%b",
                         bus.out_valid, bus.out_ss, bus.out_last, h_ss, h_last);
            end
        end
        hold   = rst_n && bus.out_valid && !bus.out_ready;
        h_d    = bus.out_data;
        h_ss   = bus.out_ss;
        h_last = bus.out_last;
        if (rst_n && bus.out_valid && bus.out_ready) begin
            n_rx++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL vec_unexpected: got ss=%0d want no vector", bus.out_ss);
            end else begin
                v = exp_q.pop_front();
                check_vec(v);
            end
        end
    end

    task automatic push_granule(input int g, input int bank);
        vec_t v;
        wr_t  w;
        for (int ss = 0; ss < NSS; ss++) begin
            v.d = '0;
            for (int sb = 0; sb < NSB; sb++)
                v.d[sb*DW +: DW] = lane(sval(g, sb, ss), sb, ss);
            v.ss   = 5'(ss);
            v.last = (ss == NSS - 1);
            exp_q.push_back(v);
        end
        for (int i = 0; i < BSZ; i++) begin
            w.a = 11'(bank * BSZ + i);
            w.d = sval(g, i / NSS, i % NSS);
            wq.push_back(w);
        end
    endtask

    // Call with time #1 after a posedge; returns #1 after the last write edge.
    task automatic send_granule(input int g);
        int t;
        push_granule(g, wbank);
        wbank ^= 1;
        for (int i = 0; i < BSZ; i++) begin
            bus.in_data  = sval(g, i / NSS, i % NSS);
            bus.in_valid = 1'b1;
            t = 0;
            @(negedge clk);
            while (!bus.in_ready) begin
                stalls++;
                t++;
                if (t > 5000) timeout("in_ready");
                @(negedge clk);
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string nm);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 6000) begin
            @(negedge clk);
            t++;
        end
        chk(nm, 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3 rst_n = 1'b0;
        exp_q.delete();
        wq.delete();
        wbank = 0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic toggle_until(input int tgt);
        int t;
        t = 0;
        while (n_rx < tgt && t < 6000) begin
            @(posedge clk);
            #1 bus.out_ready = ~bus.out_ready;
            t++;
        end
        bus.out_ready = 1'b1;
    endtask

    initial begin
        int n;
        int hs;
        int t;
        int tgt;
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_ram_we", 64'(bus.ram_we), 64'd0);
        chk("rst_out_ss", 64'(bus.out_ss), 64'd0);
        chk("rst_out_last", 64'(bus.out_last), 64'd0);
        chk("rst_out_data", 64'(bus.out_data == '0), 64'd1);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // single granule, free-running filterbank
        bus.out_ready = 1'b1;
        send_granule(0);
        chk("t1_no_stall", 64'(stalls), 64'd0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.out_valid && n < 200);
        // last write, one IDLE cycle, one cycle to enter GATHER, then 32+LAT
        chk("t1_latency", 64'(n), 64'(NSB + LAT + 2));
        wait_drain("t1_drain");

        // three granules, filterbank stalled until both banks are full
        do_reset();
        bus.out_ready = 1'b0;
        send_granule(1);
        send_granule(2);
        @(negedge clk);
        chk("t2_in_ready_full", 64'(bus.in_ready), 64'd0);
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        hs = 0;
        t = 0;
        while (hs < NSS) begin
            @(negedge clk);
            t++;
            if (t > 3000) timeout("t2_handshakes");
            if (bus.out_valid && bus.out_ready) begin
                hs++;
                if (hs == NSS) chk("t2_in_ready_last_hs", 64'(bus.in_ready), 64'd0);
            end
        end
        @(negedge clk);
        chk("t2_in_ready_freed", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        send_granule(3);
        wait_drain("t2_drain");

        // filterbank accepting every other cycle
        tgt = n_rx + NSS;
        fork
            send_granule(4);
            toggle_until(tgt);
        join
        wait_drain("t4_drain");

        // asynchronous reset in the middle of a gather
        send_granule(5);
        repeat (10) @(posedge clk);
        #3 rst_n = 1'b0;
        exp_q.delete();
        wq.delete();
        wbank = 0;
        #1;
        chk("t5_out_valid", 64'(bus.out_valid), 64'd0);
        chk("t5_in_ready", 64'(bus.in_ready), 64'd1);
        chk("t5_ram_addr", 64'(bus.ram_addr), 64'd0);
        chk("t5_out_data", 64'(bus.out_data == '0), 64'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("t5_ram_we_in_reset", 64'(bus.ram_we), 64'd0);
        @(posedge clk);
        #3 bus.in_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_granule(7);
        wait_drain("t5_drain");

        // constant samples; odd/odd lanes differ only with frequency inversion
        send_granule(6);
        wait_drain("t6_drain");

        chk("writes_left", 64'(wq.size()), 64'd0);
        summary();
        $finish;
    end
endmodule
